// File: rtl/reg_file_pkg.sv
// Shared types, default sizes and the byte-enable merge helper for the multi-port register file.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate back.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic {
        CLEAR,
        IDLE
    } sweep_state_t;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, same-cycle write bypass with byte merge, output registers.
// REG_FILE_MP_ZERO_REG_EN forces reads of address 0 to return zero.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   mem_word,
    input  logic                wr_fire,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic              in_range;
    logic              byp_hit;
    logic [DATA_W-1:0] read_word;

    // wr_fire already excludes dropped writes, so a hit always means the entry changes this edge.
    always_comb begin
        in_range  = ({1'b0, rd_addr} < DEPTH_X);
        byp_hit   = wr_fire && (wr_addr == rd_addr);
        read_word = '0;
        if (in_range) begin
            read_word = byp_hit
                ? DATA_W'(be_merge(MAX_DATA_W'(mem_word), MAX_DATA_W'(wr_data), MAX_BE_W'(wr_be)))
                : mem_word;
        end
`ifdef REG_FILE_MP_ZERO_REG_EN
        if (rd_addr == '0) read_word = '0;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= read_word;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one byte-enabled write port, NUM_RD registered read ports, zeroing sweep.
// REG_FILE_MP_ZERO_REG_EN hardwires entry 0 to zero.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  NUM_RD = DEF_NUM_RD,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    sweep_state_t      state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_word;

    always_comb begin
        wr_fire = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_X);
`ifdef REG_FILE_MP_ZERO_REG_EN
        if (wr_addr == '0) wr_fire = 1'b0;
`endif
        wr_old = '0;
        if ({1'b0, wr_addr} < DEPTH_X) wr_old = mem[wr_addr];
    end

    assign wr_word = DATA_W'(be_merge(MAX_DATA_W'(wr_old), MAX_DATA_W'(wr_data), MAX_BE_W'(wr_be)));

    // Sweep counter stops at DEPTH-1 so non-power-of-two depths never touch unused addresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_word;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            word = '0;
            if ({1'b0, addr} < DEPTH_X) word = mem[addr];
        end

        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clock    (clock),
            .reset_n  (reset_n),
            .rd_en    (rd_en[p] && !busy),
            .rd_addr  (addr),
            .mem_word (word),
            .wr_fire  (wr_fire),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_be    (wr_be),
            .rd_data  (rd_data[p*DATA_W +: DATA_W]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a DEPTH=32 and a DEPTH=20 instance share all inputs.
// Expectations for address 0 follow REG_FILE_MP_ZERO_REG_EN.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

`ifdef REG_FILE_MP_ZERO_REG_EN
    localparam logic [DW-1:0] Z0 = 32'h0000_0000;
    localparam logic [DW-1:0] Z1 = 32'h0000_0000;
`else
    localparam logic [DW-1:0] Z0 = 32'hFFFF_FFFF;
    localparam logic [DW-1:0] Z1 = 32'hFFFF_56FF;
`endif

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b1;
    logic             wr_en     = 1'b0;
    logic [AW-1:0]    wr_addr   = '0;
    logic [DW-1:0]    wr_data   = '0;
    logic [DW/8-1:0]  wr_be     = '0;
    logic [NR-1:0]    rd_en     = '0;
    logic [NR*AW-1:0] rd_addr   = '0;
    logic             clear_req = 1'b0;

    logic [NR*DW-1:0] rd_data, rd_data20;
    logic [NR-1:0]    rd_valid, rd_valid20;
    logic             busy, busy20;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    reg_file_mp #(.DATA_W(DW), .DEPTH(32), .NUM_RD(NR)) dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .clear_req(clear_req), .busy(busy)
    );

    reg_file_mp #(.DATA_W(DW), .DEPTH(20), .NUM_RD(NR)) dut20 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data20), .rd_valid(rd_valid20), .clear_req(clear_req), .busy(busy20)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        logic [1:0]    re;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        wr_en = 1'b0; wr_be = '0; wr_data = '0; wr_addr = '0;
        rd_en = '0; rd_addr = '0; clear_req = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_en   = v.we;
        wr_addr = v.wa;
        wr_data = v.wd;
        wr_be   = v.be;
        rd_en   = v.re;
        rd_addr = {v.ra1, v.ra0};
    endtask

    function automatic logic [DW-1:0] exp20(input int a);
        case (a)
            0:       return Z1;
            5:       return 32'hDE22_BE44;
            9:       return 32'h0000_F00D;
            default: return 32'h0;
        endcase
    endfunction

    // Counts sampled cycles with busy high, starting at the current negedge.
    task automatic measureBusy(input string name);
        int n32 = 0;
        int n20 = 0;
        for (int c = 0; c < 200; c++) begin
            if (busy) n32++;
            if (busy20) n20++;
            if (!busy && !busy20) break;
            @(negedge clock);
        end
        checkOutput({name, " busy cycles d32"}, DW'(n32), 32'd32);
        checkOutput({name, " busy cycles d20"}, DW'(n20), 32'd20);
    endtask

    task automatic readAllZero(input string name, input logic with20);
        for (int a = 0; a < 32; a++) begin
            rd_en = 2'b11;
            rd_addr = {AW'(31 - a), AW'(a)};
            @(negedge clock);
            checkOutput({name, " p0 data"}, rd_data[DW-1:0], 32'h0);
            checkOutput({name, " p1 data"}, rd_data[2*DW-1:DW], 32'h0);
            checkOutput({name, " valid"}, DW'(rd_valid), 32'd3);
            if (with20) begin
                checkOutput({name, " d20 p0 data"}, rd_data20[DW-1:0], 32'h0);
                checkOutput({name, " d20 valid"}, DW'(rd_valid20), 32'd3);
            end
        end
        setIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 4'b1111, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         4'b0000, 2'b01, 5'd5,  5'd0, 32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd5,  32'h1122_3344, 4'b0101, 2'b11, 5'd7,  5'd5, 32'h0,         32'hDE22_BE44};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         4'b0000, 2'b11, 5'd5,  5'd5, 32'hDE22_BE44, 32'hDE22_BE44};
        vecs[4]  = '{1'b1, 5'd31, 32'hA5A5_A5A5, 4'b1000, 2'b01, 5'd31, 5'd0, 32'hA500_0000, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         4'b0000, 2'b11, 5'd31, 5'd5, 32'hA500_0000, 32'hDE22_BE44};
        vecs[6]  = '{1'b1, 5'd9,  32'hCAFE_F00D, 4'b0011, 2'b11, 5'd9,  5'd9, 32'h0000_F00D, 32'h0000_F00D};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         4'b0000, 2'b00, 5'd0,  5'd0, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 4'b1111, 2'b01, 5'd0,  5'd0, Z0,            32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         4'b0000, 2'b10, 5'd0,  5'd0, 32'h0,         Z0};
        vecs[10] = '{1'b1, 5'd0,  32'h1234_5678, 4'b0010, 2'b11, 5'd0,  5'd0, Z1,            Z1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         4'b0000, 2'b01, 5'd0,  5'd0, Z1,            32'h0};

        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset busy", DW'(busy), 32'd1);
        checkOutput("reset busy d20", DW'(busy20), 32'd1);
        checkOutput("reset valid", DW'(rd_valid), 32'd0);
        checkOutput("reset p0 data", rd_data[DW-1:0], 32'h0);
        checkOutput("reset p1 data", rd_data[2*DW-1:DW], 32'h0);

        reset_n = 1'b1;
        measureBusy("post-reset");
        readAllZero("post-reset zero", 1'b1);

        // Table-driven writes, reads, bypass and byte merges
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkOutput($sformatf("vec%0d valid", i), DW'(rd_valid), DW'(vecs[i].re));
            if (vecs[i].re[0]) checkOutput($sformatf("vec%0d p0 data", i), rd_data[DW-1:0], vecs[i].exp0);
            if (vecs[i].re[1]) checkOutput($sformatf("vec%0d p1 data", i), rd_data[2*DW-1:DW], vecs[i].exp1);
        end
        setIdle();

        // Out-of-range write/read on the DEPTH=20 instance
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'hABCD_1234; wr_be = 4'b1111;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd25};
        @(negedge clock);
        checkOutput("oor bypass d20 data", rd_data20[DW-1:0], 32'h0);
        checkOutput("oor bypass d20 valid", DW'(rd_valid20[0]), 32'd1);
        setIdle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd25};
        @(negedge clock);
        checkOutput("oor read d20 data", rd_data20[DW-1:0], 32'h0);
        checkOutput("oor read d20 valid", DW'(rd_valid20[0]), 32'd1);
        for (int a = 0; a < 20; a++) begin
            rd_en = 2'b11;
            rd_addr = {AW'(a), AW'(a)};
            @(negedge clock);
            checkOutput($sformatf("d20 entry%0d p0", a), rd_data20[DW-1:0], exp20(a));
            checkOutput($sformatf("d20 entry%0d p1", a), rd_data20[2*DW-1:DW], exp20(a));
        end
        setIdle();

        // Clear sweep with accesses attempted while busy
        rd_en = 2'b11; rd_addr = {5'd9, 5'd5};
        @(negedge clock);
        checkOutput("pre-clear p0", rd_data[DW-1:0], 32'hDE22_BE44);
        checkOutput("pre-clear p1", rd_data[2*DW-1:DW], 32'h0000_F00D);
        setIdle();
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        checkOutput("clear busy rise", DW'(busy), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF; wr_be = 4'b1111;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        begin
            int n = 0;
            for (int c = 0; c < 100; c++) begin
                if (!busy) break;
                n++;
                checkOutput("busy valid", DW'(rd_valid), 32'd0);
                checkOutput("busy p0 hold", rd_data[DW-1:0], 32'hDE22_BE44);
                checkOutput("busy p1 hold", rd_data[2*DW-1:DW], 32'h0000_F00D);
                @(negedge clock);
            end
            checkOutput("clear busy cycles", DW'(n), 32'd32);
        end
        setIdle();
        readAllZero("post-clear zero", 1'b0);

        // Reset pulsed mid-sweep restarts the sweep
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("mid-sweep busy", DW'(busy), 32'd1);
        #2 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        measureBusy("mid-sweep reset");
        readAllZero("final zero", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
